// File: rtl/prog_clock_divider_if.sv
// Divisor write port for prog_clock_divider: valid/ready, one write per accepted cycle.
// cfg_ready is combinational from cfg_ch and the target channel's pending flag.
interface prog_clock_divider_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 24
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [CH_W-1:0] cfg_ch;
  logic [DIV_W-1:0] cfg_div;

  modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: registered clk_out/tick per channel; PHASE_TICK_EN adds tick_mid.
// Outputs are flops aligned with cnt; a divisor write stalls only while that channel already has one pending.
module prog_clock_divider #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = CLK_HZ / 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ch_en,
  prog_clock_divider_if.slave cfg,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick
`ifdef PHASE_TICK_EN
  ,
  output logic [NUM_CH-1:0]   tick_mid
`endif
);
  typedef logic [DIV_W-1:0] div_t;

  localparam div_t DEF_DIV = div_t'(DEFAULT_DIV);
  localparam div_t MIN_DIV = div_t'(2);
  localparam div_t ONE     = div_t'(1);

  div_t [NUM_CH-1:0] cnt_q, cnt_d;
  div_t [NUM_CH-1:0] div_act_q, div_act_d;
  div_t [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;

  logic [NUM_CH-1:0] cfg_hit;
  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] load;
  div_t              div_in;

  // Out-of-range channel numbers hit nothing, so they see ready=1 and are dropped.
  always_comb begin
    cfg_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_hit[i] = (32'(cfg.cfg_ch) == i);
    end
  end

  assign cfg.cfg_ready = ~|(cfg_hit & pending_q);
  assign div_in        = (cfg.cfg_div < MIN_DIV) ? MIN_DIV : cfg.cfg_div;

  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    clk_out_d = '0;
    tick_d    = '0;
    wr        = '0;
    wrap      = '0;
    load      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i]   = cfg.cfg_valid & cfg.cfg_ready & cfg_hit[i];
      wrap[i] = (cnt_q[i] == div_act_q[i] - ONE);
      // Running channels swap divisors only at a wrap so the old period always completes.
      load[i] = pending_q[i] & (~ch_en[i] | wrap[i]);

      if (load[i]) begin
        div_act_d[i] = shadow_q[i];
      end
      // A write never coincides with a load on its own channel: ready is low while pending.
      pending_d[i] = (pending_q[i] & ~load[i]) | wr[i];
      if (wr[i]) begin
        shadow_d[i] = div_in;
      end

      if (!ch_en[i] || wrap[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end

      clk_out_d[i] = ch_en[i] & (cnt_d[i] >= (div_act_d[i] >> 1));
      tick_d[i]    = ch_en[i] & (cnt_d[i] == div_act_d[i] - ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      div_act_q <= {NUM_CH{DEF_DIV}};
      shadow_q  <= {NUM_CH{DEF_DIV}};
      pending_q <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

`ifdef PHASE_TICK_EN
  logic [NUM_CH-1:0] tick_mid_q, tick_mid_d;

  // Mid-period strobe coincides with the clk_out rising edge.
  always_comb begin
    tick_mid_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tick_mid_d[i] = ch_en[i] & (cnt_d[i] == (div_act_d[i] >> 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_mid_q <= '0;
    end else begin
      tick_mid_q <= tick_mid_d;
    end
  end

  assign tick_mid = tick_mid_q;
`endif
endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares; the model tracks each channel by period start cycle.
module tb_prog_clock_divider;
  localparam int NCH  = 3;
  localparam int DW   = 8;
  localparam int DEFD = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] ch_en = '0;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] tick_mid;

  prog_clock_divider_if #(.NUM_CH(NCH), .DIV_W(DW)) ifc ();

  prog_clock_divider #(
    .CLK_HZ(50_000_000), .NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DEFD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ch_en(ch_en),
    .cfg(ifc),
    .clk_out(clk_out),
    .tick(tick)
`ifdef PHASE_TICK_EN
    ,
    .tick_mid(tick_mid)
`endif
  );

`ifndef PHASE_TICK_EN
  assign tick_mid = '0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    int             cyc;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] tick_mid;
    logic           rdy;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: each running channel remembers the cycle its current period began.
  int cyc = 0;
  bit run[NCH];
  int start[NCH];
  int per[NCH];
  bit pend[NCH];
  int shad[NCH];

  function automatic int pos_in(int i, int c);
    return run[i] ? (c - start[i]) : 0;
  endfunction

  function automatic int next_pos(int i);
    return pos_in(i, cyc + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      run[i] = 0; start[i] = 0; per[i] = DEFD; pend[i] = 0; shad[i] = DEFD;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  task automatic cycle(input logic [NCH-1:0] en, input bit v, input int ch, input int dv);
    exp_t e;
    bit   acc;
    int   p;
    @(posedge clk); #1;
    cyc++;
    ch_en = en;
    ifc.cfg_valid = v;
    ifc.cfg_ch = 2'(ch);
    ifc.cfg_div = 8'(dv);
    e = '0;
    e.cyc = cyc;
    for (int i = 0; i < NCH; i++) begin
      p = pos_in(i, cyc);
      e.clk_out[i]  = run[i] && (p >= per[i] / 2);
      e.tick[i]     = run[i] && (p == per[i] - 1);
`ifdef PHASE_TICK_EN
      e.tick_mid[i] = run[i] && (p == per[i] / 2);
`endif
    end
    e.rdy = (ch >= NCH) ? 1'b1 : !pend[ch];
    exp_q.push_back(e);
    acc = v && e.rdy;
    // Advance the model to the state after the coming edge.
    for (int i = 0; i < NCH; i++) begin
      p = pos_in(i, cyc);
      if (en[i]) begin
        if (!run[i]) begin run[i] = 1; start[i] = cyc; end
        if (p == per[i] - 1) begin
          start[i] = cyc + 1;
          if (pend[i]) begin per[i] = shad[i]; pend[i] = 0; end
        end
      end else begin
        run[i] = 0;
        if (pend[i]) begin per[i] = shad[i]; pend[i] = 0; end
      end
    end
    if (acc && ch < NCH) begin
      shad[ch] = (dv < 2) ? 2 : dv;
      pend[ch] = 1;
    end
  endtask

  task automatic idle(input logic [NCH-1:0] en, input int n);
    for (int k = 0; k < n; k++) cycle(en, 1'b0, 0, 0);
  endtask

  task automatic wait_pos(input int i, input int target, input logic [NCH-1:0] en);
    for (int k = 0; k < 64; k++) begin
      if (next_pos(i) == target) return;
      cycle(en, 1'b0, 0, 0);
    end
    miscompares++;
    $display("FAIL wait_pos ch=%0d got=%0d want=%0d (timeout)", i, next_pos(i), target);
  endtask

  // Asserted half a cycle away from any edge; outputs must drop before the next edge.
  task automatic do_reset();
    @(negedge clk); #1;
    ifc.cfg_ch = '0;
    rst = 1'b1;
    #1;
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_tick_mid", int'(tick_mid), 0);
    check("rst_cfg_ready", int'(ifc.cfg_ready), 1);
    ch_en = '0;
    ifc.cfg_valid = 1'b0;
    ifc.cfg_div = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("clk_out", int'(clk_out), int'(e.clk_out));
        check("tick", int'(tick), int'(e.tick));
`ifdef PHASE_TICK_EN
        check("tick_mid", int'(tick_mid), int'(e.tick_mid));
`endif
        check("cfg_ready", int'(ifc.cfg_ready), int'(e.rdy));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [NCH-1:0] en;
    ifc.cfg_valid = 1'b0;
    ifc.cfg_ch = '0;
    ifc.cfg_div = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Default divisor on ch0/ch1: tick every 10, clk_out low 5 / high 5.
    idle(3'b011, 25);
    // Mid-period write of 3 to ch0; old period finishes, ready low until the wrap.
    wait_pos(0, 4, 3'b011);
    cycle(3'b011, 1'b1, 0, 3);
    idle(3'b011, 20);
    // Divisor 0 on ch1 clamps to 2.
    cycle(3'b011, 1'b1, 1, 0);
    idle(3'b011, 12);
    // Write landing exactly in ch0's wrap cycle.
    wait_pos(0, 2, 3'b011);
    cycle(3'b011, 1'b1, 0, 10);
    idle(3'b011, 25);
    // Disable ch0 at cnt=4, then re-enable.
    wait_pos(0, 4, 3'b011);
    cycle(3'b010, 1'b0, 0, 0);
    idle(3'b010, 4);
    idle(3'b011, 25);
    // Write to a disabled channel, then out-of-range channel write.
    cycle(3'b011, 1'b1, 2, 4);
    idle(3'b011, 3);
    cycle(3'b111, 1'b1, 3, 7);
    idle(3'b111, 15);
    // Reset at cnt=7 with a write pending on ch0.
    wait_pos(0, 5, 3'b111);
    cycle(3'b111, 1'b1, 0, 5);
    idle(3'b111, 2);
    do_reset();
    idle(3'b001, 22);

    en = 3'b111;
    for (int n = 0; n < 2500; n++) begin
      for (int b = 0; b < NCH; b++) begin
        if ($urandom_range(0, 39) == 0) en[b] = ~en[b];
      end
      if (n == 1200) do_reset();
      cycle(en, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
